mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single memory port between instruction fetch (requester 0) and the data-memory stage (requester 1).
//   Registered FSM grants one owner per transaction and holds the port until the memory acknowledges.
//   A registered select drives mux_2x1 instances that steer address, write-data and write-enable onto the port.
//   Sits between the IF/MEM pipeline stages and the unified memory; o_busy feeds the hazard/stall unit.
// PARAMETERS
//   ADDR_W      16  memory address width
//   DATA_W      16  memory write-data width
//   STARVE_MAX  4   consecutive req1 grants tolerated while req0 waits (used only with ARB_STARVE_GUARD_EN)
// PORTS
//   i_clk        in   1       clock, all state on rising edge
//   i_reset      in   1       asynchronous, active-high reset
//   i_req0       in   1       fetch request, held until o_done0
//   i_addr0      in   ADDR_W  fetch address
//   i_req1       in   1       data request, held until o_done1
//   i_we1        in   1       data write enable (1=store, 0=load)
//   i_addr1      in   ADDR_W  data address
//   i_wdata1     in   DATA_W  store data
//   o_gnt0       out  1       port owned by requester 0
//   o_gnt1       out  1       port owned by requester 1
//   o_mem_req    out  1       memory access active
//   o_mem_we     out  1       memory write strobe
//   o_mem_addr   out  ADDR_W  muxed address
//   o_mem_wdata  out  DATA_W  muxed write data (0 when requester 0 owns port)
//   i_mem_ack    in   1       memory completes current access this cycle
//   o_done0      out  1       1-cycle pulse: fetch access complete
//   o_done1      out  1       1-cycle pulse: data access complete
//   o_busy       out  1       o_gnt0 | o_gnt1
// BEHAVIOUR
//   States: IDLE, OWN0, OWN1 (2-bit encoding). Reset: state=IDLE; all outputs 0; starve count 0.
//   Arbitration: in IDLE, and in OWN0/OWN1 on the i_mem_ack cycle, pick next owner from current i_req0/i_req1.
//   Fixed priority: i_req1 beats i_req0 (avoids MEM-stage deadlock); none requesting -> IDLE.
//   Latency: request seen in IDLE -> grant/o_mem_req asserted next cycle; 1 cycle request-to-port.
//   o_gnt*/o_mem_req are registered state decodes; held high until i_mem_ack.
//   Address/data/we are combinational mux of live inputs via the registered select; requester holds them stable until done.
//   o_mem_we = o_gnt1 & i_we1; o_mem_wdata = o_gnt1 ? i_wdata1 : 0.
//   o_doneN = registered: 1 in the cycle after i_mem_ack while OWNN; same edge may start next owner (back-to-back, no bubble).
//   i_mem_ack in IDLE: ignored, no done pulse.
//   Requester drops req mid-access: access still completes, done still pulses; no re-grant unless req reasserted.
//   Both req on ack cycle of OWN1: OWN1 again (priority), unless starvation guard overrides.
//   Reset mid-access: immediate return to IDLE, outputs 0, outstanding access abandoned, late ack ignored.
// CONFIGURATION
//   ARB_STARVE_GUARD_EN defined: counter (clog2(STARVE_MAX+1) bits) increments on each OWN1 grant made while i_req0=1;
//     clears on any OWN0 grant or i_req0=0; at STARVE_MAX, next arbitration grants requester 0 even if i_req1=1.
//   Not defined: pure fixed priority, counter absent; requester 0 may starve indefinitely.
// STRUCTURE
//   Shared header arb_defs.vh: state encodings ARB_IDLE=2'b00, ARB_OWN0=2'b01, ARB_OWN1=2'b10.
//   Sub-module: mux_2x1 #(.N(ADDR_W)) for address; mux_2x1 #(.N(DATA_W)) for write data; sel = o_gnt1.
//   FSM, done pulses and starvation counter live in this module.
// TESTING
//   Reset: assert i_reset with i_req0=1 mid-OWN0 -> all outputs 0 same cycle; ack 2 cycles later -> no o_done0.
//   Single fetch: i_req0=1,i_addr0=0x0040, ack after 3 cycles -> o_gnt0 1..3 cycles, o_mem_addr=0x0040, o_done0 one pulse.
//   Contention: i_req0=i_req1=1 from IDLE, i_we1=1,i_addr1=0x0100,i_wdata1=0xBEEF -> OWN1 first, o_mem_we=1, then OWN0.
//   Back-to-back: both held, ack every cycle -> no IDLE cycle between grants; one done pulse per ack.
//   Starvation (ARB_STARVE_GUARD_EN, STARVE_MAX=4): both held -> exactly 4 OWN1 grants then one OWN0; without macro -> OWN0 never.
//   Spurious ack in IDLE and req drop mid-access -> no done in IDLE; dropped access still yields its done pulse.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM state encoding.
// The optional starvation guard is enabled with the ARB_STARVE_GUARD_EN macro (see mem_port_arbiter.sv).
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_OWN0 = 2'b01,
    ARB_OWN1 = 2'b10
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_mux_2x1.sv
// Plain N-bit 2:1 mux used to steer requester signals onto the memory port.
module mux_2x1 #(
  parameter int N = 16
) (
  input  logic         i_sel,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between fetch (req0) and data (req1); req1 has fixed priority.
// Define ARB_STARVE_GUARD_EN to force a req0 grant after STARVE_MAX consecutive req1 grants.
//
// state    | meaning
// ARB_IDLE | port free, arbitrate every cycle
// ARB_OWN0 | fetch owns the port until i_mem_ack
// ARB_OWN1 | data stage owns the port until i_mem_ack
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic              i_req1,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  output logic              o_done0,
  output logic              o_done1,
  output logic              o_busy
);

  arb_state_t r_state;
  arb_state_t w_next;
  logic       r_gnt0;
  logic       r_gnt1;
  logic       r_done0;
  logic       r_done1;
  logic       w_arb;
  logic       w_force0;
  logic       w_busy;

  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] r_starve;

  assign w_force0 = i_req0 && (r_starve >= CNT_W'(STARVE_MAX));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_starve <= '0;
    end else if (!i_req0) begin
      r_starve <= '0;
    end else if (w_arb && (w_next == ARB_OWN0)) begin
      r_starve <= '0;
    end else if (w_arb && (w_next == ARB_OWN1) && (r_starve < CNT_W'(STARVE_MAX))) begin
      r_starve <= r_starve + 1'b1;
    end
  end
`else
  assign w_force0 = 1'b0;
`endif

  // Owners release the port only on the ack cycle, which is also when the next owner is chosen.
  assign w_arb = (r_state == ARB_IDLE) || i_mem_ack;

  always_comb begin
    w_next = r_state;
    if (w_arb) begin
      if (w_force0)    w_next = ARB_OWN0;
      else if (i_req1) w_next = ARB_OWN1;
      else if (i_req0) w_next = ARB_OWN0;
      else             w_next = ARB_IDLE;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ARB_IDLE;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
    end else begin
      r_state <= w_next;
      r_gnt0  <= (w_next == ARB_OWN0);
      r_gnt1  <= (w_next == ARB_OWN1);
      r_done0 <= (r_state == ARB_OWN0) && i_mem_ack;
      r_done1 <= (r_state == ARB_OWN1) && i_mem_ack;
    end
  end

  mux_2x1 #(.N(ADDR_W)) u_addr_mux (
    .i_sel (r_gnt1),
    .i_a   (i_addr0),
    .i_b   (i_addr1),
    .o_y   (w_addr)
  );

  mux_2x1 #(.N(DATA_W)) u_wdata_mux (
    .i_sel (r_gnt1),
    .i_a   ({DATA_W{1'b0}}),
    .i_b   (i_wdata1),
    .o_y   (w_wdata)
  );

  assign w_busy      = r_gnt0 | r_gnt1;
  assign o_gnt0      = r_gnt0;
  assign o_gnt1      = r_gnt1;
  assign o_busy      = w_busy;
  assign o_mem_req   = w_busy;
  assign o_mem_we    = r_gnt1 & i_we1;
  // Address is parked at zero while the port is idle so a reset leaves every output low.
  assign o_mem_addr  = w_addr & {ADDR_W{w_busy}};
  assign o_mem_wdata = w_wdata;
  assign o_done0     = r_done0;
  assign o_done1     = r_done1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int STARVE_MAX = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic              i_req0, i_req1, i_we1, i_mem_ack;
  logic [ADDR_W-1:0] i_addr0, i_addr1;
  logic [DATA_W-1:0] i_wdata1;
  logic              o_gnt0, o_gnt1, o_mem_req, o_mem_we, o_done0, o_done1, o_busy;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req0(i_req0), .i_addr0(i_addr0),
    .i_req1(i_req1), .i_we1(i_we1), .i_addr1(i_addr1), .i_wdata1(i_wdata1),
    .o_gnt0(o_gnt0), .o_gnt1(o_gnt1), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack),
    .o_done0(o_done0), .o_done1(o_done1), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: who owns the port (0 none, 1 fetch, 2 data), pending done pulses, run of data grants while fetch waits.
  int m_owner  = 0;
  bit m_done0  = 0;
  bit m_done1  = 0;
  int m_streak = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_owner = 0; m_done0 = 0; m_done1 = 0; m_streak = 0;
  endtask

  // One clock edge worth of behaviour, from the inputs present before the edge.
  task automatic model_edge();
    bit ack_done;
    int nxt;
    if (i_reset) begin
      model_reset();
      return;
    end
    ack_done = (m_owner != 0) && i_mem_ack;
    m_done0  = ack_done && (m_owner == 1);
    m_done1  = ack_done && (m_owner == 2);
    nxt      = m_owner;
    if (m_owner == 0 || ack_done) begin
      if (GUARD && i_req0 && m_streak >= STARVE_MAX) nxt = 1;
      else if (i_req1) nxt = 2;
      else if (i_req0) nxt = 1;
      else nxt = 0;
      if (nxt == 1) m_streak = 0;
      else if (nxt == 2 && i_req0) m_streak++;
    end
    if (!i_req0) m_streak = 0;
    m_owner = nxt;
  endtask

  task automatic check_all(input string tag);
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
    e_addr  = (m_owner == 1) ? i_addr0 : (m_owner == 2) ? i_addr1 : '0;
    e_wdata = (m_owner == 2) ? i_wdata1 : '0;
    check({tag, ".gnt0"},  32'(o_gnt0),      32'(m_owner == 1));
    check({tag, ".gnt1"},  32'(o_gnt1),      32'(m_owner == 2));
    check({tag, ".req"},   32'(o_mem_req),   32'(m_owner != 0));
    check({tag, ".busy"},  32'(o_busy),      32'(m_owner != 0));
    check({tag, ".we"},    32'(o_mem_we),    32'((m_owner == 2) && i_we1));
    check({tag, ".addr"},  32'(o_mem_addr),  32'(e_addr));
    check({tag, ".wdata"}, 32'(o_mem_wdata), 32'(e_wdata));
    check({tag, ".done0"}, 32'(o_done0),     32'(m_done0));
    check({tag, ".done1"}, 32'(o_done1),     32'(m_done1));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge i_clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    int gnt0_cycles, done0_pulses, own1_run, saw_idle, dones, acks;
    bit seen0;
    i_reset = 1; i_req0 = 0; i_req1 = 0; i_we1 = 0; i_mem_ack = 0;
    i_addr0 = '0; i_addr1 = '0; i_wdata1 = '0;
    model_reset();
    #1 check_all("reset_init");
    step("reset_hold");
    i_reset = 0;
    step("idle");

    // Single fetch: ack in the third owned cycle, fetch drops its request with the ack.
    i_req0 = 1; i_addr0 = 16'h0040;
    gnt0_cycles = 0; done0_pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (gnt0_cycles == 3) begin i_mem_ack = 1; i_req0 = 0; end
      else i_mem_ack = 0;
      step("fetch");
      if (o_gnt0) begin gnt0_cycles++; check("fetch.addr40", 32'(o_mem_addr), 32'h0040); end
      if (o_done0) done0_pulses++;
    end
    i_mem_ack = 0;
    check("fetch.gnt_cycles", 32'(gnt0_cycles), 32'd3);
    check("fetch.done_pulses", 32'(done0_pulses), 32'd1);

    // Contention from idle: store wins first, then the fetch.
    i_req0 = 1; i_addr0 = 16'h0044;
    i_req1 = 1; i_we1 = 1; i_addr1 = 16'h0100; i_wdata1 = 16'hBEEF;
    step("cont.first");
    check("cont.gnt1", 32'(o_gnt1), 32'd1);
    check("cont.we", 32'(o_mem_we), 32'd1);
    check("cont.addr", 32'(o_mem_addr), 32'h0100);
    check("cont.wdata", 32'(o_mem_wdata), 32'hBEEF);
    i_mem_ack = 1; i_req1 = 0;
    step("cont.ack1");
    check("cont.then_gnt0", 32'(o_gnt0), 32'd1);
    check("cont.done1", 32'(o_done1), 32'd1);
    i_req0 = 0;
    step("cont.ack0");
    i_mem_ack = 0; i_we1 = 0;
    step("cont.idle");

    // Back-to-back with both held and ack every cycle; also measures the req1 run before req0 gets in.
    i_req0 = 1; i_req1 = 1; i_mem_ack = 1;
    saw_idle = 0; dones = 0; acks = 0; own1_run = 0; seen0 = 0;
    step("b2b.start");
    for (int c = 0; c < 12; c++) begin
      if (!o_busy) saw_idle++;
      if (o_gnt1 && !seen0) own1_run++;
      if (o_gnt0) seen0 = 1;
      if (o_busy) acks++;
      step("b2b");
      dones += int'(o_done0) + int'(o_done1);
    end
    check("b2b.no_bubble", 32'(saw_idle), 32'd0);
    check("b2b.done_per_ack", 32'(dones), 32'(acks));
    check("starve.own1_run", 32'(own1_run), GUARD ? 32'(STARVE_MAX) : 32'd12);
    check("starve.own0_seen", 32'(seen0), 32'(GUARD));
    i_req0 = 0; i_req1 = 0;
    step("b2b.drain");
    i_mem_ack = 0;
    step("b2b.idle");

    // Spurious ack in idle, then a data load dropped mid-access.
    i_mem_ack = 1;
    step("spur.idle");
    check("spur.no_done", 32'(o_done0 | o_done1), 32'd0);
    i_mem_ack = 0; i_req1 = 1; i_we1 = 0; i_addr1 = 16'h0200;
    step("drop.grant");
    i_req1 = 0;
    step("drop.held");
    check("drop.still_owned", 32'(o_gnt1), 32'd1);
    i_mem_ack = 1;
    step("drop.ack");
    check("drop.done1", 32'(o_done1), 32'd1);
    check("drop.no_regrant", 32'(o_busy), 32'd0);
    i_mem_ack = 0;
    step("drop.idle");

    // Reset mid-OWN0: outputs clear without a clock edge, the late ack is ignored.
    i_req0 = 1; i_addr0 = 16'h0080;
    step("rst.grant");
    check("rst.gnt0_before", 32'(o_gnt0), 32'd1);
    #2 i_reset = 1;
    model_reset();
    #1 check_all("rst.async");
    step("rst.hold1");
    i_mem_ack = 1;
    step("rst.late_ack");
    check("rst.no_done0", 32'(o_done0), 32'd0);
    i_mem_ack = 0; i_req0 = 0;
    step("rst.hold3");
    i_reset = 0;
    step("rst.release");

    // Random traffic under the request/hold-until-done protocol, with occasional early drops.
    for (int c = 0; c < 400; c++) begin
      if (i_req0 && (m_done0 || $urandom_range(19) == 0)) i_req0 = 0;
      else if (!i_req0 && $urandom_range(2) == 0) begin i_req0 = 1; i_addr0 = 16'($urandom); end
      if (i_req1 && (m_done1 || $urandom_range(19) == 0)) i_req1 = 0;
      else if (!i_req1 && $urandom_range(2) == 0) begin
        i_req1 = 1; i_addr1 = 16'($urandom); i_wdata1 = 16'($urandom); i_we1 = 1'($urandom);
      end
      i_mem_ack = 1'($urandom);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
